rvfi_reorder_buffer: RTL

- Producer-side companion to the RVFI consumers (causal, ordering and register checks).
- Sits between an out-of-order core's retirement taps and a single RVFI channel.
- Accepts retirement records tagged with `order` in any sequence and re-emits them on `rvfi_*` strictly in increasing `order`, one per cycle, gap-free from 0.
- Checkers downstream then see a well-formed, causal, in-order stream.

---
 rtl/rvfi_reorder_pkg.sv | 38 +++
 rtl/rvfi_reorder_store.sv | 40 ++++
 rtl/rvfi_reorder_buffer.sv | 110 +++++++++++
 3 files changed

// File: rtl/rvfi_reorder_pkg.sv
// Shared types for the RVFI reorder buffer: the buffered retirement record,
// the input classification and the window classifier.
package rvfi_reorder_pkg;

    localparam int ENTRY_XLEN = 32;

    typedef struct packed {
        logic [63:0]           order;
        logic [31:0]           insn;
        logic [ENTRY_XLEN-1:0] pc_rdata;
        logic [4:0]            rs1_addr;
        logic [4:0]            rs2_addr;
        logic [4:0]            rd_addr;
        logic [ENTRY_XLEN-1:0] rd_wdata;
        logic                  trap;
    } rvfi_reorder_entry_t;

    typedef enum logic [1:0] {
        IN_WINDOW,
        STALE,
        AHEAD
    } rvfi_class_e;

    // Orders behind next_order by less than half the 64-bit space count as
    // already retired; anything past the window counts as ahead.
    function automatic rvfi_class_e classify(input logic [63:0] in_order,
                                             input logic [63:0] next_order,
                                             input int unsigned depth);
        logic [63:0] delta;
        logic [63:0] behind;
        delta  = in_order - next_order;
        behind = next_order - in_order;
        if (delta < 64'(depth)) return IN_WINDOW;
        if ((behind != 64'd0) && !behind[63]) return STALE;
        return AHEAD;
    endfunction

endpackage

// File: rtl/rvfi_reorder_store.sv
// Slot array for the reorder buffer: one record and one valid bit per slot,
// with a write port for arrivals and a read/clear port for the drain head.
module rvfi_reorder_store
    import rvfi_reorder_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [$clog2(DEPTH)-1:0]   wr_index,
    input  rvfi_reorder_entry_t        wr_entry,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   rd_index,
    input  logic                       re,
    output logic [DEPTH-1:0]           valid,
    output rvfi_reorder_entry_t        rd_entry
);

    rvfi_reorder_entry_t mem [DEPTH];

    // NOTE: the payload array has no reset; the valid bits alone decide
    // whether a slot's contents mean anything.
    always_ff @(posedge clock) begin
        if (we) mem[wr_index] <= wr_entry;
    end

    // Write and clear never target the same slot: the drained head is valid,
    // so an arrival for it is a dropped duplicate.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid <= '0;
        end else begin
            if (re) valid[rd_index] <= 1'b0;
            if (we) valid[wr_index] <= 1'b1;
        end
    end

    assign rd_entry = mem[rd_index];

endmodule

// File: rtl/rvfi_reorder_buffer.sv
// Reorders retirement records tagged with `order` and emits them on a single
// RVFI channel strictly in increasing order, one per cycle, gap-free.
module rvfi_reorder_buffer
    import rvfi_reorder_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter int          DEPTH       = 8,
    // Starting value of next_order after reset; 0 in normal use.
    parameter logic [63:0] RESET_ORDER = 64'd0
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [63:0]              in_order,
    input  logic [31:0]              in_insn,
    input  logic [XLEN-1:0]          in_pc_rdata,
    input  logic [4:0]               in_rs1_addr,
    input  logic [4:0]               in_rs2_addr,
    input  logic [4:0]               in_rd_addr,
    input  logic [XLEN-1:0]          in_rd_wdata,
    input  logic                     in_trap,
    output logic                     rvfi_valid,
    output logic [63:0]              rvfi_order,
    output logic [31:0]              rvfi_insn,
    output logic [XLEN-1:0]          rvfi_pc_rdata,
    output logic [4:0]               rvfi_rs1_addr,
    output logic [4:0]               rvfi_rs2_addr,
    output logic [4:0]               rvfi_rd_addr,
    output logic [XLEN-1:0]          rvfi_rd_wdata,
    output logic                     rvfi_trap,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     err_sticky
);

    localparam int IW = $clog2(DEPTH);
    localparam int OW = IW + 1;

    logic [63:0]         next_order;
    rvfi_class_e         in_class;
    rvfi_reorder_entry_t wr_entry;
    rvfi_reorder_entry_t rd_entry;
    logic [DEPTH-1:0]    slot_valid;
    logic                slot_busy;
    logic                store;
    logic                drain;
    logic                err_set;

    always_comb begin
        wr_entry = '{order: in_order, insn: in_insn, pc_rdata: in_pc_rdata,
                     rs1_addr: in_rs1_addr, rs2_addr: in_rs2_addr,
                     rd_addr: in_rd_addr, rd_wdata: in_rd_wdata, trap: in_trap};
        in_class  = classify(in_order, next_order, DEPTH);
        in_ready  = (in_class != AHEAD);
        slot_busy = slot_valid[in_order[IW-1:0]];
        store     = in_valid && (in_class == IN_WINDOW) && !slot_busy;
        err_set   = in_valid && ((in_class == STALE) ||
                                 ((in_class == IN_WINDOW) && slot_busy));
        drain     = slot_valid[next_order[IW-1:0]];
    end

    rvfi_reorder_store #(
        .DEPTH (DEPTH)
    ) u_store (
        .clock    (clock),
        .resetn   (resetn),
        .wr_index (in_order[IW-1:0]),
        .wr_entry (wr_entry),
        .we       (store),
        .rd_index (next_order[IW-1:0]),
        .re       (drain),
        .valid    (slot_valid),
        .rd_entry (rd_entry)
    );

    // NOTE: every register here is assigned with <= so all of them sample
    // the same pre-edge values of drain, store and next_order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            next_order    <= RESET_ORDER;
            rvfi_valid    <= 1'b0;
            rvfi_order    <= '0;
            rvfi_insn     <= '0;
            rvfi_pc_rdata <= '0;
            rvfi_rs1_addr <= '0;
            rvfi_rs2_addr <= '0;
            rvfi_rd_addr  <= '0;
            rvfi_rd_wdata <= '0;
            rvfi_trap     <= 1'b0;
            occupancy     <= '0;
            err_sticky    <= 1'b0;
        end else begin
            rvfi_valid <= drain;
            if (drain) begin
                rvfi_order    <= rd_entry.order;
                rvfi_insn     <= rd_entry.insn;
                rvfi_pc_rdata <= rd_entry.pc_rdata;
                rvfi_rs1_addr <= rd_entry.rs1_addr;
                rvfi_rs2_addr <= rd_entry.rs2_addr;
                rvfi_rd_addr  <= rd_entry.rd_addr;
                rvfi_rd_wdata <= rd_entry.rd_wdata;
                rvfi_trap     <= rd_entry.trap;
                next_order    <= next_order + 64'd1;
            end
            occupancy <= occupancy + OW'(store) - OW'(drain);
            if (err_set) err_sticky <= 1'b1;
        end
    end

endmodule
